fp_normalise: RTL
=================

// Module: fp_normalise
// PURPOSE
//  Normalisation stage directly downstream of the leading-zero counter in the float datapath.
//  It counts leading zeros in a mantissa, left-shifts until the MSB is 1 and subtracts the count from the exponent.
//  It has a 2-stage valid/ready pipeline and feeds the rounding/pack stage.
// PARAMETERS
//  MANT_W   24    mantissa width in bits; out_mant[MANT_W-1] is 1 after normalisation
//  EXP_W    10    exponent width, signed two's complement
//  EXP_MIN  -126  smallest legal exponent; the underflow/denormal threshold
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous reset, active-high
//  in_valid   in   1               input beat valid
//  in_ready   out  1               stage can accept an input beat
//  in_mant    in   MANT_W          unsigned mantissa
//  in_exp     in   EXP_W           signed exponent
//  out_valid  out  1               output beat valid
//  out_ready  in   1               consumer accepts the output beat
//  out_mant   out  MANT_W          normalised mantissa
//  out_exp    out  EXP_W           adjusted exponent, signed
//  out_lz     out  clog2(MANT_W+1) leading-zero count of in_mant
//  out_zero   out  1               in_mant was all zero
//  out_uflow  out  1               exponent fell below EXP_MIN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: the asynchronous assert clears all valids and every output data register to 0.
//   - in_ready is 1 from the first cycle after reset deasserts.
//  Transfer: a beat transfers when valid & ready are both high on a rising clk edge.
//  Stage 1 (S1):
//   - registers in_mant and in_exp.
//   - registers lz = number of leading zeros of in_mant, range 0..MANT_W.
//  Stage 2 (S2):
//   - out_mant = S1 mant << shift.
//   - out_exp = S1 exp - shift, computed in EXP_W+1 bits.
//  Latency: exactly 2 cycles from input accept to out_valid when out_ready is held high.
//   - Throughput is 1 beat per cycle.
//  Flow control, per stage:
//   - A stage loads when it is empty or its content leaves in the same cycle.
//   - in_ready = ~s1_valid | (~s2_valid | out_ready).
//   - No combinational path from in_valid to out_valid.
//  Output stability: outputs hold stable while out_valid & ~out_ready.
//  Zero mantissa (lz = MANT_W):
//   - out_zero = 1, out_mant = 0, out_exp = 0, out_uflow = 0.
//  Already normalised (lz = 0): mantissa and exponent pass through unchanged.
//  Underflow: when in_exp - lz < EXP_MIN, behaviour follows CONFIGURATION.
//  Mid-operation reset: in-flight beats are discarded and out_valid drops immediately.
// CONFIGURATION
//  Macro NORM_DENORM_EN.
//  Defined:
//   - shift = min(lz, in_exp - EXP_MIN), floored at 0.
//   - On clamping, out_exp = EXP_MIN and out_uflow = 1.
//   - out_mant is then a partially shifted denormal and its MSB may be 0.
//  Undefined:
//   - shift = lz, so out_mant is always normalised.
//   - On underflow, out_exp saturates to EXP_MIN and out_uflow = 1.
//  out_lz always reports the true lz, whether or not the macro is defined.
// STRUCTURE
//  Shared package fp_pkg holds:
//   - localparams for MANT_W, EXP_W, EXP_MIN and LZ_W = clog2(MANT_W+1);
//   - typedefs mant_t, exp_t, lz_t.
//  One sub-module, lz_count:
//   - combinational recursive halving leading-zero counter;
//   - each pair node emits msbs_are_zero / lsbs_are_zero;
//   - instantiated in S1.
//  Shifter and exponent subtract stay inline in S2.
// TESTING  (MANT_W=24, EXP_W=10, EXP_MIN=-126)
//  mant=0x000001 exp=0 -> 2 cycles later mant=0x800000 exp=-23 lz=23 zero=0 uflow=0
//  mant=0x800000 exp=5 -> mant=0x800000 exp=5 lz=0; back-to-back beats give 1 output/cycle
//  mant=0x000000 exp=40 -> zero=1 mant=0 exp=0 lz=24 uflow=0
//  mant=0x000100 exp=-120 (lz=15):
//   - undefined -> mant=0x800000 exp=-126 uflow=1
//   - NORM_DENORM_EN -> shift 6, mant=0x004000 exp=-126 uflow=1
//  out_ready=0 for 5 cycles, 3 beats offered -> 2 accepted, in_ready=0 afterwards,
//   outputs stable, all 3 delivered in order once out_ready=1
//  rst pulsed with 2 beats in flight -> out_valid=0 same cycle, no stale beat after release

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and sizing for the float normalisation datapath.
//   MANT_W  : mantissa width; a normalised mantissa has bit MANT_W-1 set
//   EXP_W   : exponent width, signed two's complement
//   EXP_MIN : smallest legal exponent (underflow / denormal threshold)
//   LZ_W    : width of a leading-zero count in 0..MANT_W
package fp_pkg;

  localparam int MANT_W  = 24;
  localparam int EXP_W   = 10;
  localparam int EXP_MIN = -126;
  localparam int LZ_W    = $clog2(MANT_W + 1);

  typedef logic        [MANT_W-1:0] mant_t;
  typedef logic signed [EXP_W-1:0]  exp_t;
  typedef logic        [LZ_W-1:0]   lz_t;

endpackage

// File: rtl/lz_count.sv
// Combinational leading-zero counter built by recursive halving.
// Each node splits its input into an upper (msbs) and lower (lsbs) half,
// counts each half with a child node and combines:
//   lz = msbs_are_zero ? |upper| + lz(lower) : lz(upper)
// Ports:
//   d_i    : input vector, W bits
//   lz_o   : number of leading zeros, 0..W
//   zero_o : d_i is all zero (lz_o == W)
module lz_count #(
  parameter int W  = 24,
  parameter int LW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d_i,
  output logic [LW-1:0] lz_o,
  output logic          zero_o
);

  if (W == 1) begin : g_leaf
    assign zero_o = ~d_i[0];
    assign lz_o   = LW'(zero_o);
  end else begin : g_node
    // Upper half takes the extra bit for odd widths.
    localparam int WH  = W - W / 2;
    localparam int WL  = W / 2;
    localparam int HLW = $clog2(WH + 1);
    localparam int LLW = $clog2(WL + 1);

    logic [HLW-1:0] hi_lz;
    logic [LLW-1:0] lo_lz;
    logic           msbs_are_zero;
    logic           lsbs_are_zero;

    lz_count #(.W(WH)) u_hi (
      .d_i   (d_i[W-1:WL]),
      .lz_o  (hi_lz),
      .zero_o(msbs_are_zero)
    );

    lz_count #(.W(WL)) u_lo (
      .d_i   (d_i[WL-1:0]),
      .lz_o  (lo_lz),
      .zero_o(lsbs_are_zero)
    );

    assign zero_o = msbs_are_zero & lsbs_are_zero;
    assign lz_o   = msbs_are_zero ? (LW'(WH) + LW'(lo_lz)) : LW'(hi_lz);
  end

endmodule

// File: rtl/fp_normalise.sv
// Normalisation stage after the leading-zero counter: shifts the mantissa
// left until its MSB is 1 and lowers the exponent by the shift amount.
// Two-stage valid/ready pipeline, 1 beat/cycle, 2-cycle latency.
//   S1: register mantissa, exponent and leading-zero count
//   S2: shift mantissa, adjust exponent, flag zero / underflow
// Build option NORM_DENORM_EN:
//   defined   - shift is limited so the exponent stops at EXP_MIN, leaving a
//               partially shifted (denormal) mantissa
//   undefined - shift is always the full lz; exponent saturates at EXP_MIN
//   Both set out_uflow when in_exp - lz < EXP_MIN. out_lz is always the true lz.
// Ports:
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : input handshake
//   in_mant, in_exp      : unsigned mantissa, signed exponent
//   out_valid/out_ready  : output handshake
//   out_mant, out_exp    : normalised mantissa, adjusted exponent
//   out_lz               : leading-zero count of the input mantissa
//   out_zero, out_uflow  : zero mantissa, exponent underflow
module fp_normalise
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [LZ_W-1:0]   out_lz,
  output logic              out_zero,
  output logic              out_uflow
);

  localparam logic signed [EXP_W:0] EMIN_X = (EXP_W + 1)'(EXP_MIN);

  // ---------------- handshake ----------------
  logic s1_valid_q, s2_valid_q;
  logic s1_ready, s2_ready;

  // A stage accepts when empty or when its current beat moves on this cycle.
  assign s2_ready = ~s2_valid_q | out_ready;
  assign s1_ready = ~s1_valid_q | s2_ready;
  assign in_ready = s1_ready;

  // ---------------- S1 ----------------
  mant_t s1_mant_q;
  exp_t  s1_exp_q;
  lz_t   s1_lz_q, s1_lz_d;
  logic  s1_zero_q, s1_zero_d;

  lz_count #(.W(MANT_W)) u_lz (
    .d_i   (in_mant),
    .lz_o  (s1_lz_d),
    .zero_o(s1_zero_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_lz_q    <= '0;
      s1_zero_q  <= 1'b0;
    end else if (s1_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mant_q <= in_mant;
        s1_exp_q  <= in_exp;
        s1_lz_q   <= s1_lz_d;
        s1_zero_q <= s1_zero_d;
      end
    end
  end

  // ---------------- S2 datapath ----------------
  logic signed [EXP_W:0] exp_x, lz_x, diff_x;
  lz_t   shift;
  logic  s2_uflow_d;
  mant_t s2_mant_d;
  exp_t  s2_exp_d;
`ifdef NORM_DENORM_EN
  logic signed [EXP_W:0] head_x;
`endif

  always_comb begin
    // One guard bit so exp - lz cannot wrap.
    exp_x      = {s1_exp_q[EXP_W-1], s1_exp_q};
    lz_x       = $signed({{(EXP_W + 1 - LZ_W){1'b0}}, s1_lz_q});
    diff_x     = exp_x - lz_x;
    s2_uflow_d = ~s1_zero_q & (diff_x < EMIN_X);
`ifdef NORM_DENORM_EN
    // Shift only as far as the exponent can drop before reaching EXP_MIN.
    head_x = exp_x - EMIN_X;
    if (head_x <= 0)        shift = '0;
    else if (head_x < lz_x) shift = head_x[LZ_W-1:0];
    else                    shift = s1_lz_q;
`else
    shift = s1_lz_q;
`endif
    if (s1_zero_q) begin
      s2_mant_d = '0;
      s2_exp_d  = '0;
    end else begin
      s2_mant_d = s1_mant_q << shift;
      s2_exp_d  = s2_uflow_d ? EXP_W'(EXP_MIN) : diff_x[EXP_W-1:0];
    end
  end

  // ---------------- S2 registers ----------------
  logic  out_uflow_q, out_zero_q;
  mant_t out_mant_q;
  exp_t  out_exp_q;
  lz_t   out_lz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_lz_q    <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      // Data only moves with a beat, so a stalled output holds steady.
      if (s1_valid_q) begin
        out_mant_q  <= s2_mant_d;
        out_exp_q   <= s2_exp_d;
        out_lz_q    <= s1_lz_q;
        out_zero_q  <= s1_zero_q;
        out_uflow_q <= s2_uflow_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_lz    = out_lz_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;

endmodule
